// File: rtl/ca_rule_scheduler.sv
// Sequencer for the elementary-CA datapath: cell timing, row-type controls, scrolling rule table.
// Latency: timing flags are combinational from the beam; rule/band update one cycle after each cell-row start.
// Backpressure: cfg_ready drops only during the 8-cycle COMMIT window; a held request waits there.
module ca_rule_scheduler #(
  parameter int LOG_CELL  = 2,
  parameter int GRID_W    = 160,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int ROW_CNT_W = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       video_active,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [2:0] cfg_slot,
  input  logic [7:0] cfg_rule,
  input  logic       reseed_req,
  output logic       grid_en,
  output logic [7:0] cell_x,
  output logic       cell_stb,
  output logic       seed_row,
  output logic       compute_row,
  output logic       capture_row,
  output logic [7:0] rule,
  output logic [2:0] band,
  output logic       frame_stb
);

  localparam int CELL  = 1 << LOG_CELL;
  localparam int COL_W = 10 - LOG_CELL;

  // Horizontal offset that centres the grid inside the visible line.
  localparam logic [9:0]          X_OFF    = 10'((H_ACTIVE - GRID_W * CELL) / 2);
  localparam logic [COL_W-1:0]    GRID_LIM = COL_W'(GRID_W);
  localparam logic [LOG_CELL-1:0] SUB_LAST = '1;
  localparam logic [9:0]          CELL_Y   = 10'(CELL);
  localparam logic [9:0]          V_END    = 10'(V_ACTIVE);

  localparam logic [7:0] DEF_RULES [8] = '{8'd30, 8'd110, 8'd22, 8'd73,
                                           8'd90, 8'd146, 8'd105, 8'd102};

  typedef enum logic [1:0] {
    S_WAIT,
    S_SEED,
    S_RUN,
    S_COMMIT
  } state_t;

  state_t               state;
  logic [2:0]           commit_idx;
  logic [ROW_CNT_W-1:0] scroll;
  logic [ROW_CNT_W-1:0] row_cnt;
  logic [ROW_CNT_W-1:0] row_nxt;
  logic                 reseed_pend;
  logic [7:0]           active_tbl [8];
  logic [7:0]           shadow_tbl [8];

  logic [9:0]       x_rel;
  logic [COL_W-1:0] col;
  logic             in_frame;
  logic             at_origin;
  logic             at_vblank;
  logic             row_start;
  logic             cfg_fire;

  // Beam-derived cell timing.
  assign x_rel    = pix_x - X_OFF;
  assign col      = x_rel[9:LOG_CELL];
  assign cell_x   = 8'(col);
  assign in_frame = (state == S_SEED) || (state == S_RUN);

  assign grid_en     = video_active && (col < GRID_LIM);
  assign cell_stb    = grid_en && (x_rel[LOG_CELL-1:0] == SUB_LAST) && (state != S_WAIT);
  assign compute_row = in_frame && (pix_y[LOG_CELL-1:0] == '0);
  assign capture_row = in_frame && (pix_y == CELL_Y);
  // The seed pattern covers the whole first cell row, i.e. every line of it.
  assign seed_row    = (state == S_SEED) && (pix_y < CELL_Y);

  assign at_origin = (pix_x == '0) && (pix_y == '0);
  assign at_vblank = (pix_x == '0) && (pix_y == V_END);

  // A cell row starts on pixel 0 of its first line. While waiting, only the
  // frame origin counts, so the row-0 band is loaded on the same edge that
  // leaves WAIT and nothing moves after a mid-frame reset.
  assign row_start = (pix_x == '0) && (pix_y[LOG_CELL-1:0] == '0) && (pix_y < V_END) &&
                     ((state != S_WAIT) || (pix_y == '0));
  assign row_nxt   = scroll + ROW_CNT_W'(pix_y >> LOG_CELL);
  assign band      = row_cnt[ROW_CNT_W-1 -: 3];

  assign cfg_fire = cfg_valid && cfg_ready;

  // Frame sequencer: WAIT -> SEED/RUN -> COMMIT (8 cycles) -> WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_WAIT;
      commit_idx  <= '0;
      scroll      <= '0;
      reseed_pend <= 1'b1;
      cfg_ready   <= 1'b1;
      frame_stb   <= 1'b0;
    end else begin
      frame_stb <= 1'b0;
      case (state)
        S_WAIT: begin
          if (at_origin) begin
            if (reseed_pend) begin
              state       <= S_SEED;
              reseed_pend <= 1'b0;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_SEED, S_RUN: begin
          if (at_vblank) begin
            state      <= S_COMMIT;
            commit_idx <= '0;
            frame_stb  <= 1'b1;
            scroll     <= scroll + 1'b1;
            cfg_ready  <= 1'b0;
          end
        end
        S_COMMIT: begin
          commit_idx <= commit_idx + 1'b1;
          if (commit_idx == 3'd7) begin
            state     <= S_WAIT;
            cfg_ready <= 1'b1;
          end
        end
        default: state <= S_WAIT;
      endcase
      // Placed last so a request coinciding with SEED entry is not lost.
      if (reseed_req) begin
        reseed_pend <= 1'b1;
      end
    end
  end

  // Rule tables: config writes land in the shadow, COMMIT copies one slot per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        active_tbl[i] <= DEF_RULES[i];
        shadow_tbl[i] <= DEF_RULES[i];
      end
    end else begin
      if (state == S_COMMIT) begin
        active_tbl[commit_idx] <= shadow_tbl[commit_idx];
      end
      if (cfg_fire) begin
        shadow_tbl[cfg_slot] <= cfg_rule;
      end
    end
  end

  // Scrolled row counter and the rule it selects, held for the whole cell row.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt <= '0;
      rule    <= DEF_RULES[0];
    end else if (row_start) begin
      row_cnt <= row_nxt;
      rule    <= active_tbl[row_nxt[ROW_CNT_W-1 -: 3]];
    end
  end

endmodule

// File: tb/tb_ca_rule_scheduler.sv
`timescale 1ns/1ps
module tb_ca_rule_scheduler;

  localparam int LOG_CELL  = 2;
  localparam int GRID_W    = 160;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int ROW_CNT_W = 11;
  localparam int CELL      = 1 << LOG_CELL;
  localparam int X_OFF     = (H_ACTIVE - GRID_W * CELL) / 2;
  localparam int ROWS_MOD  = 1 << ROW_CNT_W;
  localparam int N_ROWS    = V_ACTIVE / CELL;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic       video_active = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [2:0] cfg_slot = '0;
  logic [7:0] cfg_rule = '0;
  logic       reseed_req = 1'b0;
  logic       grid_en;
  logic [7:0] cell_x;
  logic       cell_stb;
  logic       seed_row;
  logic       compute_row;
  logic       capture_row;
  logic [7:0] rule;
  logic [2:0] band;
  logic       frame_stb;

  always #5 clk = ~clk;

  ca_rule_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .video_active (video_active),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_slot     (cfg_slot),
    .cfg_rule     (cfg_rule),
    .reseed_req   (reseed_req),
    .grid_en      (grid_en),
    .cell_x       (cell_x),
    .cell_stb     (cell_stb),
    .seed_row     (seed_row),
    .compute_row  (compute_row),
    .capture_row  (capture_row),
    .rule         (rule),
    .band         (band),
    .frame_stb    (frame_stb)
  );

  typedef struct {
    int x;
    int y;
    bit grid_en;
    int cell_x;
    bit cell_stb;
    bit seed_row;
    bit compute_row;
    bit capture_row;
    int rule;
    int band;
    bit frame_stb;
    bit cfg_ready;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Stimulus knobs
  bit         rand_on = 0;
  logic       f_cv = 1'b0;
  logic [2:0] f_cs = '0;
  logic [7:0] f_cr = '0;
  logic       f_rs = 1'b0;

  // Reference model: frame phase, scroll, tables and latched row selection.
  typedef enum {M_IDLE, M_SEED, M_RUN, M_COMMIT} mode_t;
  mode_t m_mode;
  int    m_ccnt;
  int    m_scroll;
  bit    m_reseed;
  int    m_act [8];
  int    m_shd [8];
  int    m_rule;
  int    m_band;
  bit    m_ready;
  bit    m_fstb;
  bit    m_acc;
  int    default_rules [8] = '{30, 110, 22, 73, 90, 146, 105, 102};

  function automatic void model_reset();
    m_mode   = M_IDLE;
    m_ccnt   = 0;
    m_scroll = 0;
    m_reseed = 1;
    m_rule   = default_rules[0];
    m_band   = 0;
    m_ready  = 1;
    m_fstb   = 0;
    m_acc    = 0;
    for (int i = 0; i < 8; i++) begin
      m_act[i] = default_rules[i];
      m_shd[i] = default_rules[i];
    end
  endfunction

  function automatic exp_t model_outputs(input int x, input int y);
    exp_t e;
    int   xr;
    int   col;
    bit   drawing;
    xr      = (x - X_OFF) & 1023;
    col     = xr / CELL;
    drawing = (m_mode == M_SEED) || (m_mode == M_RUN);
    e.x           = x;
    e.y           = y;
    e.grid_en     = video_active && (col < GRID_W);
    e.cell_x      = col % 256;
    e.cell_stb    = e.grid_en && (xr % CELL == CELL - 1) && (m_mode != M_IDLE);
    e.seed_row    = (m_mode == M_SEED) && (y < CELL);
    e.compute_row = drawing && (y % CELL == 0);
    e.capture_row = drawing && (y == CELL);
    e.rule        = m_rule;
    e.band        = m_band;
    e.frame_stb   = m_fstb;
    e.cfg_ready   = m_ready;
    return e;
  endfunction

  function automatic void model_step(input int x, input int y);
    int row;
    m_acc = cfg_valid && m_ready;
    if (x == 0 && y % CELL == 0 && y < V_ACTIVE && (m_mode != M_IDLE || y == 0)) begin
      row    = (m_scroll + y / CELL) % ROWS_MOD;
      m_band = row / (ROWS_MOD / 8);
      m_rule = m_act[m_band];
    end
    if (m_mode == M_COMMIT) m_act[m_ccnt] = m_shd[m_ccnt];
    if (m_acc) m_shd[cfg_slot] = cfg_rule;
    m_fstb = 0;
    if (m_mode == M_IDLE) begin
      if (x == 0 && y == 0) begin
        m_mode = m_reseed ? M_SEED : M_RUN;
        if (m_mode == M_SEED) m_reseed = 0;
      end
    end else if (m_mode == M_COMMIT) begin
      m_ccnt++;
      if (m_ccnt == 8) begin
        m_mode  = M_IDLE;
        m_ready = 1;
      end
    end else if (x == 0 && y == V_ACTIVE) begin
      m_mode   = M_COMMIT;
      m_ccnt   = 0;
      m_fstb   = 1;
      m_scroll = (m_scroll + 1) % ROWS_MOD;
      m_ready  = 0;
    end
    if (reseed_req) m_reseed = 1;
  endfunction

  // One beam position per clock; the expected response is queued for the monitor.
  task automatic tick(input int x, input int y, input bit rst);
    @(posedge clk);
    #1;
    pix_x        = 10'(x);
    pix_y        = 10'(y);
    video_active = (x < H_ACTIVE) && (y < V_ACTIVE);
    if (rand_on) begin
      cfg_valid  = ($urandom_range(0, 4) == 0);
      cfg_slot   = 3'($urandom_range(0, 7));
      cfg_rule   = 8'($urandom_range(0, 255));
      reseed_req = ($urandom_range(0, 299) == 0);
    end else begin
      cfg_valid  = f_cv;
      cfg_slot   = f_cs;
      cfg_rule   = f_cr;
      reseed_req = f_rs;
    end
    reset = rst;
    if (rst) begin
      model_reset();
    end else begin
      exp_q.push_back(model_outputs(x, y));
      model_step(x, y);
    end
  endtask

  // Deterministic frame: first two cell rows in detail (line 4 in full),
  // every other row start, then the blanking line holding COMMIT.
  task automatic frame_scan(input int wr_y, input logic [2:0] ws, input logic [7:0] wr,
                            input bit hold);
    bit hold_done;
    hold_done = 0;
    f_cs = ws;
    f_cr = wr;
    for (int y = 0; y < 2 * CELL; y++) begin
      for (int x = 0; x < ((y == CELL) ? 800 : 12); x++) begin
        f_cv = (y == wr_y) && (x == 1);
        tick(x, y, 0);
      end
    end
    for (int r = 2; r < N_ROWS; r++) begin
      for (int x = 0; x < 3; x++) begin
        f_cv = (r * CELL == wr_y) && (x == 1);
        tick(x, r * CELL, 0);
      end
    end
    f_cs = 3'd2;
    f_cr = 8'h55;
    for (int x = 0; x < 16; x++) begin
      f_cv = hold && !hold_done && (x >= 1);
      tick(x, V_ACTIVE, 0);
      if (m_acc) hold_done = 1;
    end
    f_cv = 1'b0;
    for (int x = 0; x < 4; x++) tick(x, V_ACTIVE + 20, 0);
  endtask

  task automatic fast_frame();
    f_cv = 1'b0;
    tick(0, 0, 0);
    tick(1, 0, 0);
    tick(0, V_ACTIVE, 0);
    for (int x = 1; x <= 10; x++) tick(x, V_ACTIVE, 0);
  endtask

  task automatic frame_rand();
    int n;
    int y0;
    for (int r = 0; r < N_ROWS; r++) begin
      if (r == 0 || $urandom_range(0, 2) == 0) begin
        y0 = r * CELL;
        if (r != 0 && $urandom_range(0, 7) == 0) y0 += $urandom_range(1, CELL - 1);
        n = ($urandom_range(0, 40) == 0) ? 700 : $urandom_range(1, 6);
        for (int x = 0; x < n; x++) tick(x, y0, 0);
      end
    end
    for (int x = 0; x < 12; x++) tick(x, V_ACTIVE, 0);
    for (int x = 0; x < 4; x++) tick(x, V_ACTIVE + 30, 0);
  endtask

  task automatic cmp(input string name, input exp_t e, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s at x=%0d y=%0d: got %0d, want %0d", name, e.x, e.y, got, want);
    end
  endtask

  // Monitor: every clock the DUT presents a full output vector; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("grid_en",     e, int'(grid_en),     int'(e.grid_en));
        cmp("cell_x",      e, int'(cell_x),      e.cell_x);
        cmp("cell_stb",    e, int'(cell_stb),    int'(e.cell_stb));
        cmp("seed_row",    e, int'(seed_row),    int'(e.seed_row));
        cmp("compute_row", e, int'(compute_row), int'(e.compute_row));
        cmp("capture_row", e, int'(capture_row), int'(e.capture_row));
        cmp("rule",        e, int'(rule),        e.rule);
        cmp("band",        e, int'(band),        e.band);
        cmp("frame_stb",   e, int'(frame_stb),   int'(e.frame_stb));
        cmp("cfg_ready",   e, int'(cfg_ready),   int'(e.cfg_ready));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    tick(0, 0, 1);
    tick(0, 0, 1);

    // Quiet after reset, both in blanking and inside the visible area.
    for (int x = 0; x < 10; x++) tick(x, V_ACTIVE + 20, 0);
    for (int x = 0; x < 10; x++) tick(x, 100, 0);

    // SEED frame then RUN frame.
    frame_scan(-1, 3'd0, 8'd0, 0);
    frame_scan(-1, 3'd0, 8'd0, 0);

    // Advance the scroll to 250: band boundary falls at cell row 6.
    while (m_scroll != 250) fast_frame();

    // Mid-frame write of slot 1, plus a request held across COMMIT for slot 2.
    frame_scan(5 * CELL, 3'd1, 8'hFF, 1);
    frame_scan(-1, 3'd0, 8'd0, 0);
    repeat (3) fast_frame();

    rand_on = 1;
    repeat (6) frame_rand();
    rand_on = 0;
    f_cv = 1'b0;
    f_rs = 1'b0;

    // Reset at line 200 of a visible frame, then run out the frame quietly.
    tick(0, 0, 0);
    tick(1, 0, 0);
    for (int r = 1; r < 50; r++) begin
      for (int x = 0; x < 3; x++) tick(x, r * CELL, 0);
    end
    tick(0, 200, 0);
    tick(1, 200, 0);
    tick(2, 200, 1);
    for (int x = 3; x < 21; x++) tick(x, 200, 0);
    for (int r = 51; r < N_ROWS; r++) begin
      for (int x = 0; x < 3; x++) tick(x, r * CELL, 0);
    end
    for (int x = 0; x < 16; x++) tick(x, V_ACTIVE, 0);
    for (int x = 0; x < 4; x++) tick(x, V_ACTIVE + 20, 0);
    frame_scan(-1, 3'd0, 8'd0, 0);

    rand_on = 1;
    repeat (2) frame_rand();
    rand_on = 0;
    for (int x = 0; x < 4; x++) tick(x, V_ACTIVE + 40, 0);

    @(posedge clk);
    @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending vectors, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
